fmap_ram_arbiter: RTL and testbench

FMAP_RAM_ARBITER -- requirements
Module: fmap_ram_arbiter

---
 rtl/fmap_ram_arbiter.sv | 105 ++++++++++
 tb/tb_fmap_ram_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fmap_ram_arbiter.sv
// Arbitrates a single-port feature-map RAM between a loader (writes) and the TMG
// controller (reads), with TMG burst locking bounded by MAX_LOCK consecutive grants.
module fmap_ram_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_LOCK = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    input  logic              tmg_req,
    input  logic [ADDR_W-1:0] tmg_addr,
    input  logic              tmg_lock,
    output logic              tmg_gnt,
    output logic              tmg_rvalid,
    output logic [DATA_W-1:0] tmg_rdata,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

    typedef enum logic [1:0] {OWN_NONE, OWN_LD, OWN_TMG} owner_e;
    typedef enum logic {RR_LD, RR_TMG} rr_e;

    owner_e           owner;
    rr_e              rr_last;
    logic [CNT_W-1:0] lock_cnt;
    logic             lock_q;
    logic             rd_pend;
    logic             lock_active;

    // lock_q only remembers tmg_lock from a cycle in which TMG actually owned the RAM
    assign lock_active = (owner == OWN_TMG) && lock_q && (lock_cnt < MAX_CNT);

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        ld_gnt  = 1'b0;
        tmg_gnt = 1'b0;
        if (!rst) begin
            if (tmg_req && lock_active) begin
                tmg_gnt = 1'b1;
            end else if (ld_req && tmg_req) begin
                if (rr_last == RR_TMG) ld_gnt  = 1'b1;
                else                   tmg_gnt = 1'b1;
            end else if (ld_req) begin
                ld_gnt = 1'b1;
            end else if (tmg_req) begin
                tmg_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        ram_wr   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (ld_gnt) begin
            ram_wr   = 1'b1;
            ram_addr = ld_addr;
            ram_din  = ld_wdata;
        end else if (tmg_gnt) begin
            ram_addr = tmg_addr;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner    <= OWN_NONE;
            rr_last  <= RR_TMG;
            lock_cnt <= '0;
            lock_q   <= 1'b0;
            rd_pend  <= 1'b0;
        end else begin
            lock_q  <= tmg_gnt && tmg_lock;
            rd_pend <= tmg_gnt;
            if (tmg_gnt) begin
                owner   <= OWN_TMG;
                rr_last <= RR_TMG;
                if (owner != OWN_TMG)       lock_cnt <= CNT_W'(1);
                else if (lock_cnt < MAX_CNT) lock_cnt <= lock_cnt + CNT_W'(1);
            end else begin
                lock_cnt <= '0;
                if (ld_gnt) begin
                    owner   <= OWN_LD;
                    rr_last <= RR_LD;
                end else begin
                    owner   <= OWN_NONE;
                end
            end
        end
    end

    // A read in flight when reset hits is dropped rather than returned
    assign tmg_rvalid = rd_pend && !rst;
    assign tmg_rdata  = tmg_rvalid ? ram_dout : '0;

endmodule

// File: tb/tb_fmap_ram_arbiter.sv
// Directed bench for fmap_ram_arbiter: grant sequences checked per cycle, read data via a scoreboard.
module tb_fmap_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld_req;
    logic [7:0] ld_addr;
    logic [7:0] ld_wdata;
    logic       ld_gnt;
    logic       tmg_req;
    logic [7:0] tmg_addr;
    logic       tmg_lock;
    logic       tmg_gnt;
    logic       tmg_rvalid;
    logic [7:0] tmg_rdata;
    logic       ram_wr;
    logic [7:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;

    int tests = 0;
    int fails = 0;

    logic [7:0] ram_mem [256];
    logic [7:0] exp_mem [256];
    logic [7:0] sb [$];

    fmap_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_LOCK(9)) dut (
        .clk(clk), .rst(rst),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
        .tmg_req(tmg_req), .tmg_addr(tmg_addr), .tmg_lock(tmg_lock), .tmg_gnt(tmg_gnt),
        .tmg_rvalid(tmg_rvalid), .tmg_rdata(tmg_rdata),
        .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Registered-output RAM seen by the arbiter
    always @(posedge clk) begin
        if (ram_wr) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit lr, input logic [7:0] la, input logic [7:0] lw,
                        input bit tr, input logic [7:0] ta, input bit tl,
                        input bit e_ld, input bit e_tmg, input string tag);
        logic [7:0] exp_rd;
        rst = r; ld_req = lr; ld_addr = la; ld_wdata = lw;
        tmg_req = tr; tmg_addr = ta; tmg_lock = tl;
        @(negedge clk);
        if (r) sb.delete();
        check({tag, ".ld_gnt"},  32'(ld_gnt),  32'(e_ld));
        check({tag, ".tmg_gnt"}, 32'(tmg_gnt), 32'(e_tmg));
        check({tag, ".ram_wr"},  32'(ram_wr),  32'(e_ld));
        check({tag, ".ram_addr"}, 32'(ram_addr), e_ld ? 32'(la) : (e_tmg ? 32'(ta) : 32'd0));
        check({tag, ".ram_din"},  32'(ram_din),  e_ld ? 32'(lw) : 32'd0);
        if (sb.size() > 0) begin
            exp_rd = sb.pop_front();
            check({tag, ".rvalid"}, 32'(tmg_rvalid), 32'd1);
            check({tag, ".rdata"},  32'(tmg_rdata),  32'(exp_rd));
        end else begin
            check({tag, ".rvalid"}, 32'(tmg_rvalid), 32'd0);
            check({tag, ".rdata"},  32'(tmg_rdata),  32'd0);
        end
        if (e_tmg) sb.push_back(exp_mem[ta]);
        if (e_ld)  exp_mem[la] = lw;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;
        tmg_req = 1'b0; tmg_addr = '0; tmg_lock = 1'b0;
        @(posedge clk);
        #1;

        // Reset with both requesters active: everything held at zero
        for (int i = 0; i < 2; i++) step(1, 1, 8'h10, 8'hA5, 1, 8'h10, 1, 0, 0, "reset");

        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, "idle");

        // Single requesters: write 0xA5 to 0x10, read it back one cycle later
        step(0, 1, 8'h10, 8'hA5, 0, 8'h00, 0, 1, 0, "ld_single");
        step(0, 0, 8'h00, 8'h00, 1, 8'h10, 0, 0, 1, "tmg_single");
        step(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, "rd_single");

        // Contention after reset alternates starting with LD
        step(1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, "reset2");
        for (int i = 0; i < 4; i++)
            step(0, 1, 8'h20, 8'h11 + 8'(i), 1, 8'h10, 0, (i % 2) == 0, (i % 2) == 1, "rr");

        // LD write then TMG burst reading the same address in the next cycle
        step(0, 1, 8'h30, 8'h5C, 0, 8'h00, 0, 1, 0, "ld_pre");
        for (int i = 1; i <= 12; i++)
            step(0, 1, 8'h20, 8'h77, 1, 8'h30, 1, i == 10, i != 10, "burst");
        step(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, "gap");

        // Early release: lock for 3 grants, then TMG drops its request
        step(0, 0, 8'h00, 8'h00, 1, 8'h30, 1, 0, 1, "lock1");
        step(0, 1, 8'h20, 8'h88, 1, 8'h30, 1, 0, 1, "lock2");
        step(0, 1, 8'h20, 8'h88, 1, 8'h30, 1, 0, 1, "lock3");
        step(0, 1, 8'h20, 8'h99, 0, 8'h00, 0, 1, 0, "release");
        check("release.lock_cnt", 32'(dut.lock_cnt), 32'd0);

        // Reset on burst cycle 4 drops the pending read; LD wins next contention
        for (int i = 1; i <= 3; i++) step(0, 1, 8'h20, 8'hA0, 1, 8'h30, 1, 0, 1, "burst_r");
        step(1, 1, 8'h20, 8'hA0, 1, 8'h30, 1, 0, 0, "mid_rst");
        step(0, 1, 8'h20, 8'hAA, 1, 8'h30, 0, 1, 0, "post_rst");
        step(0, 1, 8'h20, 8'hBB, 1, 8'h20, 0, 0, 1, "post_rst2");
        step(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, "drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
